lgdst_ts_deframer: RTL and testbench

Downstream consumer of the serial transport-stream port (ts_clk / ts_valid / ts_sync / ts_d0) produced by the RX glue stage. It oversamples the serial TS in the system clock domain and deserializes it MSB-first into bytes. It finds and tracks 188-byte MPEG-TS packet alignment on the 0x47 sync byte and emits a byte stream with start/end-of-packet markers. Packet and sync-error counters are exposed for status readback.

---
 rtl/lgdst_ts_deframer.sv | 197 +++++++++++++++++++
 tb/tb_lgdst_ts_deframer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lgdst_ts_deframer.sv
// Serial MPEG-TS deframer: oversamples ts_clk/ts_d0 in the clk domain, hunts and tracks
// 0x47 packet alignment, and emits a byte stream with SOP/EOP markers plus status counters.
module lgdst_ts_deframer #(
    parameter int         PKT_LEN    = 188,
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter int         LOCK_CNT   = 3,
    parameter int         UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ts_clk,
    input  logic        ts_valid,
    input  logic        ts_sync,
    input  logic        ts_d0,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        byte_sop,
    output logic        byte_eop,
    output logic        locked,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

    localparam int             BCW       = $clog2(PKT_LEN);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(PKT_LEN - 1);
    localparam logic [7:0]     LOCK_N    = 8'(LOCK_CNT);
    localparam logic [7:0]     UNLOCK_N  = 8'(UNLOCK_CNT);

    logic [2:0]     tck_q;
    logic [1:0]     vld_q, syn_q, d0_q;

    state_t         state_q, state_d;
    logic [7:0]     sr_q, sr_d;
    logic [2:0]     bit_q, bit_d;
    logic [BCW-1:0] byte_q, byte_d;
    logic [3:0]     hunt_q, hunt_d;
    logic [7:0]     good_q, good_d;
    logic [7:0]     bad_q, bad_d;
    logic [7:0]     err_q, err_d;
    logic [15:0]    pkt_q, pkt_d;
    logic [7:0]     data_q, data_d;
    logic           bv_q, bv_d;
    logic           sop_q, sop_d;
    logic           eop_q, eop_d;

    logic           take;
    logic [7:0]     sr_shift;
    logic           byte_done;
    logic           first_bit;
    logic           sync_err;
    logic           pos_err;

    // Two-flop synchronizers; the third ts_clk flop exists only for rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tck_q <= '0;
            vld_q <= '0;
            syn_q <= '0;
            d0_q  <= '0;
        end else begin
            tck_q <= {tck_q[1:0], ts_clk};
            vld_q <= {vld_q[0], ts_valid};
            syn_q <= {syn_q[0], ts_sync};
            d0_q  <= {d0_q[0], ts_d0};
        end
    end

    assign take      = tck_q[1] & ~tck_q[2] & vld_q[1];
    assign sr_shift  = {sr_q[6:0], d0_q[1]};
    assign byte_done = (bit_q == 3'd7);
    assign first_bit = (byte_q == '0) && (bit_q == 3'd0);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        hunt_d   = hunt_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = err_q;
        pkt_d    = pkt_q;
        data_d   = data_q;
        bv_d     = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        sync_err = 1'b0;
        pos_err  = 1'b0;

        if (take) begin
            sr_d = sr_shift;
            case (state_q)
                HUNT: begin
                    // hunt_q saturates at 8: only "at least a full byte seen" matters
                    if (hunt_q != 4'd8) hunt_d = hunt_q + 4'd1;
                    if (sr_shift == SYNC_BYTE && hunt_q >= 4'd7) begin
                        state_d = VERIFY;
                        bit_d   = 3'd0;
                        byte_d  = BCW'(1);
                        good_d  = 8'd1;
                    end
                end
                VERIFY: begin
                    bit_d = bit_q + 3'd1;
                    if (byte_done) begin
                        byte_d = (byte_q == LAST_BYTE) ? '0 : byte_q + BCW'(1);
                        if (byte_q == '0) begin
                            if (sr_shift == SYNC_BYTE) begin
                                good_d = good_q + 8'd1;
                                if (good_q + 8'd1 >= LOCK_N) begin
                                    state_d = LOCK;
                                    bad_d   = 8'd0;
                                end
                            end else begin
                                state_d = HUNT;
                                hunt_d  = 4'd0;
                            end
                        end
                    end
                end
                LOCK: begin
                    bit_d   = bit_q + 3'd1;
                    pos_err = syn_q[1] & ~first_bit;
                    if (byte_done) begin
                        byte_d = (byte_q == LAST_BYTE) ? '0 : byte_q + BCW'(1);
                        bv_d   = 1'b1;
                        data_d = sr_shift;
                        sop_d  = (byte_q == '0);
                        eop_d  = (byte_q == LAST_BYTE);
                        if (byte_q == LAST_BYTE) pkt_d = pkt_q + 16'd1;
                        if (byte_q == '0) begin
                            if (sr_shift == SYNC_BYTE) begin
                                bad_d = 8'd0;
                            end else begin
                                sync_err = 1'b1;
                                // the bad sync byte is still emitted; output stops after it
                                if (bad_q + 8'd1 >= UNLOCK_N) begin
                                    state_d = HUNT;
                                    bad_d   = 8'd0;
                                    hunt_d  = 4'd0;
                                end else begin
                                    bad_d = bad_q + 8'd1;
                                end
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            // simultaneous sync-byte and ts_sync errors count once
            if ((sync_err || pos_err) && err_q != 8'hFF) err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            sr_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hunt_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= '0;
            pkt_q   <= '0;
            data_q  <= '0;
            bv_q    <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            hunt_q  <= hunt_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            pkt_q   <= pkt_d;
            data_q  <= data_d;
            bv_q    <= bv_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = bv_q;
    assign byte_sop   = sop_q;
    assign byte_eop   = eop_q;
    assign locked     = (state_q == LOCK);
    assign pkt_cnt    = pkt_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_lgdst_ts_deframer.sv
// Randomized bench for lgdst_ts_deframer: serial TS at clk/4 against a packet-position
// reference model evaluated over the whole taken-bit history since the last reset.
module tb_lgdst_ts_deframer;

    localparam int         L       = 24;
    localparam int         L8      = L * 8;
    localparam logic [7:0] SYNC    = 8'h47;
    localparam int         LOCKN   = 3;
    localparam int         UNLOCKN = 3;

    logic        clk;
    logic        rst_n;
    logic        ts_clk, ts_valid, ts_sync, ts_d0;
    logic [7:0]  byte_data;
    logic        byte_valid, byte_sop, byte_eop, locked;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bit         qb[$];
    bit         qs[$];
    logic [9:0] dut_q[$];
    logic [9:0] exp_q[$];
    int         m_err, m_pkt;
    bit         m_lock;
    logic       bv_prev = 1'b0;

    lgdst_ts_deframer #(
        .PKT_LEN(L), .SYNC_BYTE(SYNC), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN)
    ) dut (
        .clk(clk), .reset(rst_n),
        .ts_clk(ts_clk), .ts_valid(ts_valid), .ts_sync(ts_sync), .ts_d0(ts_d0),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_sop(byte_sop),
        .byte_eop(byte_eop), .locked(locked), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && byte_valid) begin
            check("b2b_valid", 32'(bv_prev), 32'd0);
            dut_q.push_back({byte_sop, byte_eop, byte_data});
        end
        bv_prev = byte_valid;
    end

    function automatic logic [7:0] byte_at(int j);
        logic [7:0] v = '0;
        for (int b = 0; b < 8; b++) v = {v[6:0], qb[j+b]};
        return v;
    endfunction

    // Alignment is expressed as packet start index p0; everything else is position modulo L8.
    task automatic run_model();
        int n, hs, hit, p0, k, good, start, bad, off, bn;
        bit fail, ev, gone;
        logic [7:0] bv;
        logic sop, eop;
        n = qb.size();
        hs = 0;
        exp_q.delete();
        m_err = 0; m_pkt = 0; m_lock = 0;
        forever begin
            hit = -1;
            for (int t = hs + 7; t < n; t++)
                if (byte_at(t - 7) == SYNC) begin hit = t; break; end
            if (hit < 0) return;
            p0 = hit - 7; good = 1; k = 1; fail = 0;
            while (good < LOCKN) begin
                if (p0 + k * L8 + 7 >= n) return;
                if (byte_at(p0 + k * L8) == SYNC) begin good++; k++; end
                else begin hs = p0 + k * L8 + 8; fail = 1; break; end
            end
            if (fail) continue;
            m_lock = 1; bad = 0; gone = 0;
            start = p0 + (k - 1) * L8 + 8;
            for (int t = start; t < n; t++) begin
                off = (t - p0) % L8;
                bn  = off / 8;
                ev  = qs[t] && (off != 0);
                if (off % 8 == 7) begin
                    bv  = byte_at(t - 7);
                    sop = (bn == 0);
                    eop = (bn == L - 1);
                    exp_q.push_back({sop, eop, bv});
                    if (eop) m_pkt++;
                    if (sop) begin
                        if (bv == SYNC) bad = 0;
                        else begin
                            ev = 1; bad++;
                            if (bad == UNLOCKN) begin gone = 1; hs = t + 1; end
                        end
                    end
                end
                if (ev && m_err < 255) m_err++;
                if (gone) break;
            end
            if (!gone) return;
            m_lock = 0;
        end
    endtask

    task automatic send_bit(input bit v, input bit d, input bit s);
        ts_valid = v; ts_d0 = d; ts_sync = s;
        repeat (2) @(negedge clk);
        ts_clk = 1'b1;
        repeat (2) @(negedge clk);
        ts_clk = 1'b0;
        if (v) begin qb.push_back(d); qs.push_back(s); end
    endtask

    // spos: -1 no ts_sync, 0..7 ts_sync on that bit index, 8 ts_sync on every bit
    task automatic send_byte(input logic [7:0] b, input int spos);
        for (int i = 7; i >= 0; i--) send_bit(1'b1, b[i], (spos == 8) || (spos == i));
    endtask

    // mode 0: payload 0x00.., 1: random payload, 2: random payload with ts_sync on every bit
    task automatic send_pkt(input logic [7:0] sb, input int mode);
        send_byte(sb, 7);
        for (int j = 1; j < L; j++) begin
            if (mode == 0) send_byte(8'(j - 1), -1);
            else send_byte(8'($urandom_range(0, 255)), (mode == 2) ? 8 : -1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ts_clk = 1'b0; ts_valid = 1'b0; ts_sync = 1'b0; ts_d0 = 1'b0;
        #1;
        check("rst_data",  32'(byte_data),  32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_sop",   32'(byte_sop),   32'd0);
        check("rst_eop",   32'(byte_eop),   32'd0);
        check("rst_locked", 32'(locked),    32'd0);
        check("rst_pkt",   32'(pkt_cnt),    32'd0);
        check("rst_err",   32'(err_cnt),    32'd0);
        qb.delete(); qs.delete(); dut_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        int n, e0;
        repeat (6) @(negedge clk);
        run_model();
        check({tag, "_nbytes"}, 32'(dut_q.size()), 32'(exp_q.size()));
        n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
        e0 = n_errors;
        for (int i = 0; i < n; i++) begin
            check({tag, "_byte"}, 32'(dut_q[i]), 32'(exp_q[i]));
            if (n_errors != e0) break;
        end
        check({tag, "_err"},  32'(err_cnt), 32'(m_err));
        check({tag, "_pkt"},  32'(pkt_cnt), 32'(m_pkt));
        check({tag, "_lock"}, 32'(locked),  32'(m_lock));
    endtask

    initial begin
        logic [7:0] gb;
        rst_n = 1'b0;
        ts_clk = 1'b0; ts_valid = 1'b0; ts_sync = 1'b0; ts_d0 = 1'b0;
        @(negedge clk);
        do_reset();

        // Acquisition behind 3 junk bits
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        for (int p = 0; p < 5; p++) send_pkt(SYNC, 0);
        checkpoint("acq");
        check("acq_locked", 32'(locked), 32'd1);
        check("acq_noerr", 32'(err_cnt), 32'd0);

        // False sync: 0x47 among zeros, next byte-0 slot holds 0x00
        do_reset();
        for (int i = 0; i < 13; i++) send_bit(1'b1, 1'b0, 1'b0);
        send_byte(SYNC, 7);
        for (int j = 0; j < L + 4; j++) send_byte(8'h00, -1);
        checkpoint("fsync");
        check("fsync_locked", 32'(locked), 32'd0);
        check("fsync_nout", 32'(dut_q.size()), 32'd0);

        // Single bad sync holds lock; three consecutive bad syncs unlock
        for (int p = 0; p < 4; p++) send_pkt(SYNC, 1);
        send_pkt(8'h46, 1);
        send_pkt(SYNC, 1);
        checkpoint("hold");
        check("hold_locked", 32'(locked), 32'd1);
        check("hold_err", 32'(err_cnt), 32'd1);
        for (int p = 0; p < 2; p++) send_pkt(8'h46, 1);
        send_byte(8'h46, 7);
        for (int j = 0; j < 5; j++) send_byte(8'($urandom_range(0, 255)), -1);
        checkpoint("unlock");
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_err", 32'(err_cnt), 32'd4);
        check("unlock_last", (dut_q.size() > 0) ? 32'(dut_q[dut_q.size() - 1]) : 32'hDEAD,
              32'({1'b1, 1'b0, 8'h46}));

        // ts_valid gap of 37 periods in the middle of byte 3 of a locked packet
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(SYNC, 1);
        send_byte(SYNC, 7);
        for (int j = 0; j < 2; j++) send_byte(8'($urandom_range(0, 255)), -1);
        gb = 8'($urandom_range(0, 255));
        for (int i = 7; i >= 4; i--) send_bit(1'b1, gb[i], 1'b0);
        for (int i = 0; i < 37; i++)
            send_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 3; i >= 0; i--) send_bit(1'b1, gb[i], 1'b0);
        for (int j = 4; j < L; j++) send_byte(8'($urandom_range(0, 255)), -1);
        send_pkt(SYNC, 1);
        checkpoint("gap");
        check("gap_byte", (dut_q.size() > L + 2) ? 32'(dut_q[L + 2][7:0]) : 32'hDEAD, 32'(gb));
        check("gap_noerr", 32'(err_cnt), 32'd0);
        check("gap_locked", 32'(locked), 32'd1);

        // ts_sync one bit late, then flood of misplaced ts_sync to saturate err_cnt
        send_byte(SYNC, 6);
        for (int j = 1; j < L; j++) send_byte(8'($urandom_range(0, 255)), -1);
        checkpoint("spos");
        check("spos_err", 32'(err_cnt), 32'd1);
        check("spos_locked", 32'(locked), 32'd1);
        for (int p = 0; p < 2; p++) send_pkt(SYNC, 2);
        send_pkt(SYNC, 1);
        checkpoint("sat");
        check("sat_err", 32'(err_cnt), 32'd255);

        // Reset while locked, mid-packet; re-lock needs LOCK_CNT sync bytes
        send_byte(SYNC, 7);
        for (int j = 0; j < 5; j++) send_byte(8'($urandom_range(0, 255)), -1);
        repeat (3) @(negedge clk);
        check("pre_rst_locked", 32'(locked), 32'd1);
        do_reset();
        for (int p = 0; p < 2; p++) send_pkt(SYNC, 1);
        checkpoint("relock2");
        check("relock2_locked", 32'(locked), 32'd0);
        send_byte(SYNC, 7);
        checkpoint("relock3");
        check("relock3_locked", 32'(locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
